ram_writer: RTL and testbench

Streaming sample logger that writes a continuous AXI-Stream of 32-bit samples into external DDR through a single-beat AXI4 write master. It sits between the signal-processing chain and the PS memory interconnect and is controlled by one 32-bit GPIO word from software. Samples go into one of two ring buffers; a software request swaps the buffers so the filled one can be read while logging continues.

---
 rtl/ram_writer_pkg.sv | 38 +++
 rtl/ram_writer_throttle.sv | 32 +++
 rtl/ram_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_writer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg: shared types and field positions for the DDR sample logger.
// Holds the writer FSM encoding, GPIO/status bit-field positions, the fixed
// AXI4 single-beat write attributes and the buffer-length clamp helper.
package ram_writer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

    // GPIO control word fields
    localparam int GPIO_ENABLE_BIT  = 0;
    localparam int GPIO_REQUEST_BIT = 1;
    localparam int GPIO_LEN_LSB     = 2;
    localparam int GPIO_LEN_MSB     = 6;
    localparam int GPIO_THR_LSB     = 7;
    localparam int GPIO_THR_MSB     = 11;

    // Status word fields
    localparam int STATUS_RBUF_BIT  = 0;
    localparam int STATUS_PTR_LSB   = 1;
    localparam int STATUS_PTR_MSB   = 24;
    localparam int STATUS_OVF_BIT   = 31;
    localparam int PTR_W            = STATUS_PTR_MSB - STATUS_PTR_LSB + 1;

    // Fixed attributes of every write: one 32-bit beat, incrementing burst
    localparam logic [7:0] AXI_AWLEN   = 8'd0;
    localparam logic [2:0] AXI_AWSIZE  = 3'b010;
    localparam logic [1:0] AXI_AWBURST = 2'b01;
    localparam logic [3:0] AXI_WSTRB   = 4'hF;

    // Limit the requested log2 buffer length to what the address map allows
    function automatic logic [4:0] clamp_log_length(input logic [4:0] req,
                                                    input logic [4:0] limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/ram_writer_throttle.sv
// ram_writer_throttle: decimates the accepted sample stream.
// A 32-bit beat counter runs while logging is enabled; a beat is offered to
// the writer whenever the low log_throttle bits of the count are all zero,
// so one beat in 2^log_throttle is kept. The counter sits at 0 while disabled
// so the first beat after enabling is always a candidate.
module ram_writer_throttle (
    input  logic       aclk,
    input  logic       areset,
    input  logic       enable,
    input  logic       beat,
    input  logic [4:0] log_throttle,
    output logic       strobe
);

    logic [31:0] cnt;
    logic [31:0] mask;

    assign mask   = (32'd1 << log_throttle) - 32'd1;
    assign strobe = enable & beat & ((cnt & mask) == 32'd0);

    // Beat counter: cleared while disabled, advances on every accepted beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt <= 32'd0;
        end else if (!enable) begin
            cnt <= 32'd0;
        end else if (beat) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ram_writer.sv
// ram_writer: logs a 32-bit AXI-Stream into one of two DDR ring buffers via
// single-beat AXI4 writes. Software drives enable/request/length/throttle via
// GPIO; a request edge swaps buffers and reports where the old one stopped.
// Build option: define RAM_WRITER_OVERFLOW_EN to get a sticky overflow flag in
// status[31]; without it status[31] is 0 (dropping still happens).
module ram_writer #(
    parameter logic [31:0] BASE_ADDR      = 32'h1E00_0000,
    parameter int          MAX_LOG_LENGTH = 24,
    parameter int          DATA_W         = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [31:0]       GPIO,
    output logic [31:0]       status,
    input  logic              S_AXIS_tvalid,
    input  logic [DATA_W-1:0] S_AXIS_tdata,
    output logic              S_AXIS_tready,
    output logic [31:0]       M_AXI_awaddr,
    output logic              M_AXI_awvalid,
    input  logic              M_AXI_awready,
    output logic [7:0]        M_AXI_awlen,
    output logic [2:0]        M_AXI_awsize,
    output logic [1:0]        M_AXI_awburst,
    output logic [DATA_W-1:0] M_AXI_wdata,
    output logic              M_AXI_wvalid,
    input  logic              M_AXI_wready,
    output logic [3:0]        M_AXI_wstrb,
    output logic              M_AXI_wlast,
    input  logic              M_AXI_bvalid,
    output logic              M_AXI_bready
);

    import ram_writer_pkg::*;

    logic [1:0]       gpio_p1;
    logic             en_now;
    logic             en_rise;
    logic             req_rise;
    logic [4:0]       gpio_len;
    logic [4:0]       log_length_q;
    logic [4:0]       log_throttle_q;
    logic [4:0]       len_eff;
    logic             tready_q;
    logic             beat;
    logic             candidate;
    wr_state_t        state;
    wr_state_t        state_d;
    logic             load;
    logic             write_done;
    logic             wbuf;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_mask;
    logic [PTR_W-1:0] ptr_inc;
    logic             read_buffer;
    logic [PTR_W-1:0] ptr_at_swap;
    logic             overflow;
    logic [31:0]      buf_offset;
    logic [31:0]      ptr_offset;
    logic [31:0]      addr_d;

    wire unused_inputs = &{1'b0, GPIO[31:12], M_AXI_bvalid};

    // Control edges come from the live GPIO word against its registered copy
    assign en_now   = GPIO[GPIO_ENABLE_BIT];
    assign en_rise  = en_now & ~gpio_p1[0];
    assign req_rise = en_now & GPIO[GPIO_REQUEST_BIT] & ~gpio_p1[1];
    assign gpio_len = clamp_log_length(GPIO[GPIO_LEN_MSB:GPIO_LEN_LSB], 5'(MAX_LOG_LENGTH));

    // The sample taken on the enable edge already uses the new length; a
    // sample on a swap edge still belongs to the old buffer and old length.
    assign len_eff  = en_rise ? gpio_len : log_length_q;

    assign beat = S_AXIS_tvalid & tready_q;

    // Fixed AXI attributes
    assign M_AXI_awlen   = AXI_AWLEN;
    assign M_AXI_awsize  = AXI_AWSIZE;
    assign M_AXI_awburst = AXI_AWBURST;
    assign M_AXI_wstrb   = AXI_WSTRB;
    assign M_AXI_wlast   = 1'b1;
    assign M_AXI_bready  = 1'b1;
    assign S_AXIS_tready = tready_q;

    ram_writer_throttle u_throttle (
        .aclk         (aclk),
        .areset       (areset),
        .enable       (en_now),
        .beat         (beat),
        .log_throttle (log_throttle_q),
        .strobe       (candidate)
    );

    // Both channels are finished once each valid is low or handshaking now
    assign write_done = (~M_AXI_awvalid | M_AXI_awready) & (~M_AXI_wvalid | M_AXI_wready);

    // Target address of the sample being loaded this cycle
    assign ptr_mask   = (PTR_W'(1) << len_eff) - PTR_W'(1);
    assign ptr_inc    = (ptr + PTR_W'(1)) & ptr_mask;
    assign buf_offset = {31'd0, wbuf} << (len_eff + 5'd2);
    assign ptr_offset = {{(32-PTR_W-2){1'b0}}, ptr, 2'b00};
    assign addr_d     = BASE_ADDR + buf_offset + ptr_offset;

    // Registered copy of the enable/request bits for edge detection
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gpio_p1 <= 2'b00;
        end else begin
            gpio_p1 <= {GPIO[GPIO_REQUEST_BIT], GPIO[GPIO_ENABLE_BIT]};
        end
    end

    // Stream is accepted from the first edge after reset release
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
        end
    end

    // Length and throttle only follow GPIO on enable edges and swaps
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            log_length_q   <= 5'd0;
            log_throttle_q <= 5'd0;
        end else if (en_rise || req_rise) begin
            log_length_q   <= gpio_len;
            log_throttle_q <= GPIO[GPIO_THR_MSB:GPIO_THR_LSB];
        end
    end

    // Writer FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Writer FSM next state: load a candidate whenever the channel is free
    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (candidate) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (write_done) begin
                    if (candidate) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // AXI address/data channels: each valid clears on its own handshake
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            M_AXI_awvalid <= 1'b0;
            M_AXI_wvalid  <= 1'b0;
            M_AXI_awaddr  <= 32'd0;
            M_AXI_wdata   <= '0;
        end else if (load) begin
            M_AXI_awvalid <= 1'b1;
            M_AXI_wvalid  <= 1'b1;
            M_AXI_awaddr  <= addr_d;
            M_AXI_wdata   <= S_AXIS_tdata;
        end else begin
            M_AXI_awvalid <= M_AXI_awvalid & ~M_AXI_awready;
            M_AXI_wvalid  <= M_AXI_wvalid & ~M_AXI_wready;
        end
    end

    // Ring pointer and buffer swap bookkeeping
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wbuf        <= 1'b0;
            ptr         <= '0;
            read_buffer <= 1'b0;
            ptr_at_swap <= '0;
        end else if (req_rise) begin
            read_buffer <= wbuf;
            wbuf        <= ~wbuf;
            ptr_at_swap <= ptr;
            ptr         <= '0;
        end else if (!en_now) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= ptr_inc;
        end
    end

`ifdef RAM_WRITER_OVERFLOW_EN
    logic drop;
    assign drop = (state == WRITE) & ~write_done & candidate;

    // Sticky overflow: set by any dropped candidate, cleared by a swap
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            overflow <= 1'b0;
        end else if (req_rise) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    // Status word assembly
    always_comb begin
        status                                 = 32'd0;
        status[STATUS_RBUF_BIT]                = read_buffer;
        status[STATUS_PTR_MSB:STATUS_PTR_LSB]  = ptr_at_swap;
        status[STATUS_OVF_BIT]                 = overflow;
    end

endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed bench for ram_writer with hand-computed addresses,
// data and status words covering reset, streaming, wrap, swaps, disable,
// length clamping, throttling, back-pressure and asynchronous reset.
module tb_ram_writer;

    localparam logic [31:0] BASE = 32'h1E00_0000;
`ifdef RAM_WRITER_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic        aclk;
    logic        areset;
    logic [31:0] GPIO;
    logic [31:0] status;
    logic        S_AXIS_tvalid;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tready;
    logic [31:0] M_AXI_awaddr;
    logic        M_AXI_awvalid;
    logic        M_AXI_awready;
    logic [7:0]  M_AXI_awlen;
    logic [2:0]  M_AXI_awsize;
    logic [1:0]  M_AXI_awburst;
    logic [31:0] M_AXI_wdata;
    logic        M_AXI_wvalid;
    logic        M_AXI_wready;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_wlast;
    logic        M_AXI_bvalid;
    logic        M_AXI_bready;

    int total;
    int fails;
    logic [31:0] last_d;
    logic [31:0] t0;
    logic [31:0] o0;
    int busy;

    ram_writer dut (
        .aclk          (aclk),
        .areset        (areset),
        .GPIO          (GPIO),
        .status        (status),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXI_awaddr  (M_AXI_awaddr),
        .M_AXI_awvalid (M_AXI_awvalid),
        .M_AXI_awready (M_AXI_awready),
        .M_AXI_awlen   (M_AXI_awlen),
        .M_AXI_awsize  (M_AXI_awsize),
        .M_AXI_awburst (M_AXI_awburst),
        .M_AXI_wdata   (M_AXI_wdata),
        .M_AXI_wvalid  (M_AXI_wvalid),
        .M_AXI_wready  (M_AXI_wready),
        .M_AXI_wstrb   (M_AXI_wstrb),
        .M_AXI_wlast   (M_AXI_wlast),
        .M_AXI_bvalid  (M_AXI_bvalid),
        .M_AXI_bready  (M_AXI_bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // One clock: remember the sample presented at the edge, then advance it
    task automatic step();
        last_d = S_AXIS_tdata;
        @(posedge aclk);
        #1;
        S_AXIS_tdata = S_AXIS_tdata + 32'd1;
    endtask

    initial begin
        total = 0;
        fails = 0;
        areset = 1'b1;
        GPIO = 32'd0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata = 32'd0;
        M_AXI_awready = 1'b1;
        M_AXI_wready = 1'b1;
        M_AXI_bvalid = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", {31'd0, S_AXIS_tready}, 32'd0);
        chk("rst_awvalid", {31'd0, M_AXI_awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, M_AXI_wvalid}, 32'd0);
        chk("rst_awaddr", M_AXI_awaddr, 32'd0);
        chk("rst_wdata", M_AXI_wdata, 32'd0);
        chk("rst_status", status, 32'd0);

        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("tready_up", {31'd0, S_AXIS_tready}, 32'd1);
        chk("idle_awvalid", {31'd0, M_AXI_awvalid}, 32'd0);
        chk("awlen", {24'd0, M_AXI_awlen}, 32'd0);
        chk("awsize", {29'd0, M_AXI_awsize}, 32'd2);
        chk("awburst", {30'd0, M_AXI_awburst}, 32'd1);
        chk("wstrb", {28'd0, M_AXI_wstrb}, 32'hF);
        chk("wlast", {31'd0, M_AXI_wlast}, 32'd1);
        chk("bready", {31'd0, M_AXI_bready}, 32'd1);

        // Continuous logging, length 64 words, buffer 0, wrap after 64
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata = 32'hA000_0000;
        GPIO = 32'h19;
        for (int i = 0; i < 70; i++) begin
            step();
            chk("stream_awvalid", {31'd0, M_AXI_awvalid}, 32'd1);
            chk("stream_wvalid", {31'd0, M_AXI_wvalid}, 32'd1);
            chk("stream_awaddr", M_AXI_awaddr, BASE + 32'((i % 64) * 4));
            chk("stream_wdata", M_AXI_wdata, 32'hA000_0000 + 32'(i));
        end

        // First swap: sample on the edge lands at ptr 6 of buffer 0
        GPIO = 32'h1B;
        step();
        chk("swap1_awaddr", M_AXI_awaddr, 32'h1E00_0018);
        chk("swap1_wdata", M_AXI_wdata, 32'hA000_0046);
        chk("swap1_status", status, 32'h0000_000C);
        step();
        chk("buf1_first", M_AXI_awaddr, 32'h1E00_0100);
        GPIO = 32'h19;
        step();
        chk("buf1_second", M_AXI_awaddr, 32'h1E00_0104);

        // Second swap back to buffer 0
        GPIO = 32'h1B;
        step();
        chk("swap2_awaddr", M_AXI_awaddr, 32'h1E00_0108);
        chk("swap2_status", status, 32'h0000_0005);
        step();
        chk("buf0_restart", M_AXI_awaddr, 32'h1E00_0000);

        // Disabled: nothing written for 100 cycles
        GPIO = 32'h18;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (M_AXI_awvalid || M_AXI_wvalid) busy++;
        end
        chk("disabled_idle_cycles", 32'(busy), 32'd0);
        chk("disabled_status", status, 32'h0000_0005);
        GPIO = 32'h19;
        step();
        chk("reenable_awvalid", {31'd0, M_AXI_awvalid}, 32'd1);
        chk("reenable_awaddr", M_AXI_awaddr, 32'h1E00_0000);

        // Swap to buffer 1, then re-enable asking for length 31 (clamped to 24)
        GPIO = 32'h1B;
        step();
        chk("swap3_awaddr", M_AXI_awaddr, 32'h1E00_0004);
        chk("swap3_status", status, 32'h0000_0002);
        GPIO = 32'h18;
        step();
        step();
        GPIO = 32'h7D;
        step();
        chk("clamp_awaddr0", M_AXI_awaddr, 32'h2200_0000);
        step();
        chk("clamp_awaddr1", M_AXI_awaddr, 32'h2200_0004);

        // Throttle 3: one beat in eight, buffer 1, length 64
        GPIO = 32'h198;
        step();
        step();
        GPIO = 32'h199;
        t0 = 32'd0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (k == 0) t0 = last_d;
            chk("thr_awvalid", {31'd0, M_AXI_awvalid}, {31'd0, (k % 8) == 0});
            if ((k % 8) == 0) begin
                chk("thr_wdata", M_AXI_wdata, t0 + 32'(k));
                chk("thr_awaddr", M_AXI_awaddr, 32'h1E00_0100 + 32'((k / 8) * 4));
            end
        end

        // Back-pressure on the data channel for five cycles
        GPIO = 32'h18;
        step();
        GPIO = 32'h19;
        M_AXI_wready = 1'b0;
        step();
        o0 = last_d;
        chk("bp_awvalid0", {31'd0, M_AXI_awvalid}, 32'd1);
        chk("bp_wvalid0", {31'd0, M_AXI_wvalid}, 32'd1);
        chk("bp_awaddr0", M_AXI_awaddr, 32'h1E00_0100);
        step();
        chk("bp_awvalid1", {31'd0, M_AXI_awvalid}, 32'd0);
        chk("bp_wvalid1", {31'd0, M_AXI_wvalid}, 32'd1);
        step();
        step();
        step();
        chk("bp_wvalid4", {31'd0, M_AXI_wvalid}, 32'd1);
        chk("bp_wdata4", M_AXI_wdata, o0);
        chk("bp_status", status, {EXP_OVF, 31'h0000_0002});
        M_AXI_wready = 1'b1;
        step();
        chk("bp_resume_awvalid", {31'd0, M_AXI_awvalid}, 32'd1);
        chk("bp_resume_awaddr", M_AXI_awaddr, 32'h1E00_0104);
        chk("bp_resume_wdata", M_AXI_wdata, o0 + 32'd5);

        // Swap clears overflow
        GPIO = 32'h1B;
        step();
        chk("swap4_awaddr", M_AXI_awaddr, 32'h1E00_0108);
        chk("swap4_status", status, 32'h0000_0005);

        // Asynchronous reset in the middle of a write
        areset = 1'b1;
        #1;
        chk("areset_awvalid", {31'd0, M_AXI_awvalid}, 32'd0);
        chk("areset_wvalid", {31'd0, M_AXI_wvalid}, 32'd0);
        chk("areset_status", status, 32'd0);
        chk("areset_tready", {31'd0, S_AXIS_tready}, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
